// File: rtl/popcnt_pkg.sv
// rtl/popcnt_pkg.sv - shared state encoding and width defaults for the popcount scheduler
package popcnt_pkg;

   localparam int DW_DEFAULT   = 128;
   localparam int ACCW_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/popcnt128.sv
// rtl/popcnt128.sv - combinational exact population count of one data word
module popcnt128 #(
   parameter int DW = popcnt_pkg::DW_DEFAULT
) (
   input  logic [DW-1:0]      data,
   output logic [$clog2(DW):0] count
);

   localparam int CW = $clog2(DW) + 1;

   always_comb begin
      count = '0;
      for (int i = 0; i < DW; i++) begin
         count = count + CW'(data[i]);
      end
   end

endmodule

// File: rtl/popcnt_sched.sv
// rtl/popcnt_sched.sv - two-requester frame scheduler sharing one popcount datapath
// Round-robin grant per frame, saturating frame accumulator, result held until consumed.
module popcnt_sched
   import popcnt_pkg::*;
#(
   parameter int DW   = DW_DEFAULT,
   parameter int ACCW = ACCW_DEFAULT
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            In0_Valid,
   input  logic [DW-1:0]   In0_Data,
   input  logic            In0_Last,
   output logic            In0_Ready,
   input  logic            In1_Valid,
   input  logic [DW-1:0]   In1_Data,
   input  logic            In1_Last,
   output logic            In1_Ready,
   output logic            Res_Valid,
   output logic [ACCW-1:0] Res_Count,
   output logic            Res_Id,
   input  logic            Res_Ready
);

   localparam int CW = $clog2(DW) + 1;
   // Sum width covers both the ACCW+1 carry and a word count wider than the accumulator.
   localparam int SW = (ACCW + 1 > CW) ? ACCW + 1 : CW;
   localparam logic [SW-1:0] ACC_MAX = {{(SW - ACCW){1'b0}}, {ACCW{1'b1}}};

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_served_q, last_served_d;
   logic [ACCW-1:0]   acc_q, acc_d;

   logic [DW-1:0]     sel_data;
   logic              sel_valid;
   logic              sel_last;
   logic [CW-1:0]     word_cnt;
   logic [SW-1:0]     sum;
   logic [ACCW-1:0]   acc_sat;
   logic              any_valid;

   assign any_valid = In0_Valid || In1_Valid;
   assign sel_data  = grant_q ? In1_Data  : In0_Data;
   assign sel_valid = grant_q ? In1_Valid : In0_Valid;
   assign sel_last  = grant_q ? In1_Last  : In0_Last;

   popcnt128 #(.DW(DW)) u_popcnt (
      .data  (sel_data),
      .count (word_cnt)
   );

   assign sum     = SW'(acc_q) + SW'(word_cnt);
   assign acc_sat = (sum > ACC_MAX) ? {ACCW{1'b1}} : sum[ACCW-1:0];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_served_q <= 1'b1;
         acc_q         <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_served_q <= last_served_d;
         acc_q         <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_valid) state_d = RUN;
         RUN:     if (sel_valid && sel_last) state_d = DONE;
         DONE:    if (Res_Ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d       = grant_q;
      last_served_d = last_served_q;
      acc_d         = acc_q;
      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               grant_d = (In0_Valid && In1_Valid) ? ~last_served_q : In1_Valid;
               acc_d   = '0;
            end
         end
         RUN: begin
            if (sel_valid) acc_d = acc_sat;
         end
         DONE: begin
            // Fairness history only moves once a frame has actually been consumed.
            if (Res_Ready) last_served_d = grant_q;
         end
         default: begin
            acc_d = '0;
         end
      endcase
   end

   always_comb begin
      In0_Ready = (state_q == RUN) && !grant_q;
      In1_Ready = (state_q == RUN) && grant_q;
      Res_Valid = (state_q == DONE);
      Res_Count = acc_q;
      Res_Id    = grant_q;
   end

endmodule

// File: tb/tb_popcnt_sched.sv
// tb/tb_popcnt_sched.sv - self-checking bench for popcnt_sched (ACCW=16 and ACCW=8 instances)
module tb_popcnt_sched;

   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          in0_valid, in1_valid, in0_last, in1_last, res_ready;
   logic [DW-1:0] in0_data, in1_data;
   logic          in0_ready, in1_ready, res_valid, res_id;
   logic [15:0]   res_count;
   logic          in0_ready8, in1_ready8, res_valid8, res_id8;
   logic [7:0]    res_count8;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   popcnt_sched #(.DW(DW), .ACCW(16)) dut (
      .Clk(clk), .Rst(rst),
      .In0_Valid(in0_valid), .In0_Data(in0_data), .In0_Last(in0_last), .In0_Ready(in0_ready),
      .In1_Valid(in1_valid), .In1_Data(in1_data), .In1_Last(in1_last), .In1_Ready(in1_ready),
      .Res_Valid(res_valid), .Res_Count(res_count), .Res_Id(res_id), .Res_Ready(res_ready)
   );

   popcnt_sched #(.DW(DW), .ACCW(8)) dut8 (
      .Clk(clk), .Rst(rst),
      .In0_Valid(in0_valid), .In0_Data(in0_data), .In0_Last(in0_last), .In0_Ready(in0_ready8),
      .In1_Valid(in1_valid), .In1_Data(in1_data), .In1_Last(in1_last), .In1_Ready(in1_ready8),
      .Res_Valid(res_valid8), .Res_Count(res_count8), .Res_Id(res_id8), .Res_Ready(res_ready)
   );

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int            exp16;
      int            exp8;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } word_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
      if (in0_ready || in1_ready) check("ready_exclusive", in0_ready && in1_ready, 0);
   endtask

   task automatic put(input int k, input logic [DW-1:0] d, input logic l);
      bit done;
      done = 1'b0;
      if (k == 0) begin in0_valid = 1'b1; in0_data = d; in0_last = l; end
      else        begin in1_valid = 1'b1; in1_data = d; in1_last = l; end
      for (int i = 0; i < 50 && !done; i++) begin
         done = (k == 0) ? in0_ready : in1_ready;
         step();
      end
      if (!done) check("put_timeout", 0, 1);
      if (k == 0) in0_valid = 1'b0; else in1_valid = 1'b0;
   endtask

   task automatic take_res(input string name, input int exp_id, input int exp16, input int exp8);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (res_valid) ok = 1'b1;
         else step();
      end
      check({name, "_valid"}, ok, 1);
      check({name, "_id"}, res_id, exp_id);
      check({name, "_count16"}, res_count, exp16);
      check({name, "_count8"}, res_count8, exp8);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t          vecs[6];
      logic [DW-1:0] ones;
      word_t         q0[$], q1[$];
      int            e0[$], e1[$];
      int            got_id[$], got_cnt[$], got_cyc[$];
      int            total, nres, cyc, sum, len, mode, expv;
      bit            hs0, hs1;
      logic [DW-1:0] w;

      ones = {DW{1'b1}};
      vecs[0] = '{1'b0, '0,               0,   0};
      vecs[1] = '{1'b1, ones,             128, 128};
      vecs[2] = '{1'b0, 128'h1,           1,   1};
      vecs[3] = '{1'b1, 128'h1 << 127,    1,   1};
      vecs[4] = '{1'b0, {64{2'b10}},      64,  64};
      vecs[5] = '{1'b1, 128'hF0,          4,   4};

      rst = 1'b1;
      in0_valid = 1'b0; in1_valid = 1'b0; in0_last = 1'b0; in1_last = 1'b0;
      in0_data = '0; in1_data = '0; res_ready = 1'b0;
      step();
      step();
      check("rst_res_valid", res_valid, 0);
      check("rst_res_count", res_count, 0);
      check("rst_res_id", res_id, 0);
      check("rst_ready", {in0_ready, in1_ready}, 0);
      check("rst_res_valid8", res_valid8, 0);
      rst = 1'b0;
      step();

      // Single-word frames: ready one cycle after the grant cycle, result the cycle after that.
      foreach (vecs[i]) begin
         if (vecs[i].id == 1'b0) begin in0_valid = 1'b1; in0_data = vecs[i].data; in0_last = 1'b1; end
         else                    begin in1_valid = 1'b1; in1_data = vecs[i].data; in1_last = 1'b1; end
         check("vec_idle_ready", {in0_ready, in1_ready}, 0);
         step();
         check("vec_run_ready", vecs[i].id ? in1_ready : in0_ready, 1);
         step();
         in0_valid = 1'b0; in1_valid = 1'b0;
         check("vec_res_valid", res_valid, 1);
         check("vec_res_id", res_id, vecs[i].id);
         check("vec_count16", res_count, vecs[i].exp16);
         check("vec_count8", res_count8, vecs[i].exp8);
         res_ready = 1'b1;
         step();
         res_ready = 1'b0;
         check("vec_back_idle", res_valid, 0);
      end

      // Three-word frame on requester 0.
      put(0, ones, 1'b0);
      put(0, '0, 1'b0);
      check("f3_not_early", res_valid, 0);
      put(0, 128'hFF, 1'b1);
      check("f3_res_valid_next", res_valid, 1);
      take_res("f3", 0, 136, 136);
      check("f3_idle_after", res_valid, 0);

      // Saturation of the narrow accumulator.
      put(0, ones, 1'b0);
      put(0, ones, 1'b0);
      put(1'b0, ones, 1'b1);
      take_res("sat", 0, 384, 255);

      // Both requesters valid out of reset, held continuously: strict alternation.
      in0_valid = 1'b1; in0_data = 128'hF; in0_last = 1'b1;
      in1_valid = 1'b1; in1_data = 128'h3; in1_last = 1'b1;
      res_ready = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 40 && got_id.size() < 3; i++) begin
         step();
         cyc++;
         if (res_valid && res_ready) begin
            got_id.push_back(int'(res_id));
            got_cnt.push_back(int'(res_count));
            got_cyc.push_back(cyc);
         end
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      step();
      res_ready = 1'b0;
      check("rr_results", got_id.size(), 3);
      if (got_id.size() == 3) begin
         check("rr_id0", got_id[0], 0);
         check("rr_id1", got_id[1], 1);
         check("rr_id2", got_id[2], 0);
         check("rr_cnt0", got_cnt[0], 4);
         check("rr_cnt1", got_cnt[1], 2);
         check("rr_cnt2", got_cnt[2], 4);
         check("rr_gap1", got_cyc[1] - got_cyc[0], 3);
         check("rr_gap2", got_cyc[2] - got_cyc[1], 3);
      end
      step();

      // Result back-pressure: result held, no input accepted.
      put(1, 128'hFF, 1'b1);
      in0_valid = 1'b1; in0_data = 128'h1; in0_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", res_valid, 1);
         check("hold_count", res_count, 8);
         check("hold_id", res_id, 1);
         check("hold_ready", {in0_ready, in1_ready}, 0);
         step();
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("hold_released", res_valid, 0);
      check("hold_idle_ready", in0_ready, 0);
      step();
      check("hold_next_grant", in0_ready, 1);
      step();
      in0_valid = 1'b0;
      take_res("hold_next", 0, 1, 1);

      // Reset in the middle of a four-word frame.
      put(0, ones, 1'b0);
      put(0, ones, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rstmid_no_result", res_valid, 0);
         step();
      end
      put(0, 128'h7, 1'b1);
      take_res("rstmid_next", 0, 3, 3);

      // Valid gap inside a frame.
      put(1, 128'hFFFF, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("gap_stall_ready", in1_ready, 1);
         check("gap_no_result", res_valid, 0);
         step();
      end
      put(1, 128'h3, 1'b1);
      take_res("gap", 1, 18, 18);

      // Randomised frames from both requesters against a frame-level reference.
      total = 0;
      for (int k = 0; k < 2; k++) begin
         for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 4);
            sum = 0;
            for (int j = 0; j < len; j++) begin
               mode = $urandom_range(0, 3);
               if (mode == 0)      w = ones;
               else if (mode == 1) w = '0;
               else                w = {$urandom, $urandom, $urandom, $urandom};
               sum += $countones(w);
               if (k == 0) q0.push_back('{w, (j == len - 1)});
               else        q1.push_back('{w, (j == len - 1)});
            end
            if (k == 0) e0.push_back(sum); else e1.push_back(sum);
            total++;
         end
      end
      nres = 0;
      for (int c = 0; c < 5000 && nres < total; c++) begin
         if (!in0_valid && q0.size() > 0 && $urandom_range(0, 3) != 0) begin
            in0_valid = 1'b1; in0_data = q0[0].d; in0_last = q0[0].l;
         end
         if (!in1_valid && q1.size() > 0 && $urandom_range(0, 3) != 0) begin
            in1_valid = 1'b1; in1_data = q1[0].d; in1_last = q1[0].l;
         end
         res_ready = ($urandom_range(0, 2) != 0);
         hs0 = in0_valid && in0_ready;
         hs1 = in1_valid && in1_ready;
         if (hs0) void'(q0.pop_front());
         if (hs1) void'(q1.pop_front());
         if (res_valid) begin
            if ((res_id ? e1.size() : e0.size()) == 0) begin
               check("rand_spurious_result", 1, 0);
            end else begin
               expv = res_id ? e1[0] : e0[0];
               check("rand_count16", res_count, (expv > 65535) ? 65535 : expv);
               check("rand_count8", res_count8, (expv > 255) ? 255 : expv);
               check("rand_id8", res_id8, res_id);
               if (res_ready) begin
                  if (res_id) void'(e1.pop_front()); else void'(e0.pop_front());
                  nres++;
               end
            end
         end
         step();
         if (hs0) in0_valid = 1'b0;
         if (hs1) in1_valid = 1'b0;
      end
      res_ready = 1'b0;
      in0_valid = 1'b0; in1_valid = 1'b0;
      check("rand_results", nres, total);
      check("rand_words_left", q0.size() + q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/popcnt_sched.md
POPCNT_SCHED -- requirements
Module: popcnt_sched

Interface
REQ-001 Parameter DW, default 128, data word width fed to the shared popcount datapath.
REQ-002 Parameter ACCW, default 16, frame count accumulator and result width.
REQ-003 The block SHALL have exactly one clock and one reset: Clk is the single clock, and Rst is a synchronous, active-high reset.
REQ-004 Clk  input  1  rising-edge clock for all state.
REQ-005 Rst  input  1  synchronous active-high reset.
REQ-006 In0_Valid / In1_Valid  input  1 each  requester k presents a word.
REQ-007 In0_Data / In1_Data  input  DW each  requester k data word.
REQ-008 In0_Last / In1_Last  input  1 each  word is the final word of requester k's frame.
REQ-009 In0_Ready / In1_Ready  output  1 each  word from requester k accepted this cycle when Valid&Ready.
REQ-010 Res_Valid  output  1  frame result available.
REQ-011 Res_Count  output  ACCW  saturated popcount of the whole frame.
REQ-012 Res_Id  output  1  requester that owned the frame.
REQ-013 Res_Ready  input  1  consumer accepts the result when Res_Valid&Res_Ready.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE: if any InK_Valid, grant one requester, clear Acc, go to RUN the next cycle; In*_Ready stay 0 in IDLE.
REQ-016 Arbitration: one valid requester gets the grant; both valid grants !Last_Served (round-robin); Last_Served updates only when a frame completes.
REQ-017 RUN: InK_Ready=1 only for the granted k; the other Ready is 0; a non-granted Valid is ignored and held by its source.
REQ-018 Each accepted word: Acc <= sat(Acc + popcount(InK_Data)), with the sum taken in ACCW+1 bits and clamped to 2^ACCW-1.
REQ-019 An accepted word with Last=1 SHALL be accumulated, then the FSM goes to DONE; Res_Valid rises the cycle after that acceptance.
REQ-020 DONE: Res_Valid=1; Res_Count=Acc and Res_Id=grant, held stable until the handshake; all In*_Ready=0.
REQ-021 Res_Valid&Res_Ready in DONE: Last_Served<=grant, go to IDLE; a new grant is made at the earliest on the following IDLE cycle.
REQ-022 Single-word frame (Last on the first word): the result appears 2 cycles after the grant cycle, and Res_Count equals that word's popcount.
REQ-023 No Valid during RUN: stall with Acc unchanged; no timeout.
REQ-024 Throughput: one word per cycle in RUN; minimum per-frame overhead is 1 IDLE cycle plus 1 DONE cycle.

Reset
REQ-025 Rst=1 at a clock edge: state=IDLE, Acc=0, grant=0, Last_Served=1 (requester 0 wins the first tie), and all outputs 0.
REQ-026 Rst during RUN or DONE SHALL discard the partial frame or pending result; no Res_Valid is produced for it.

Structure
REQ-027 Package popcnt_pkg holds the state enum (IDLE, RUN, DONE) and the DW and ACCW defaults.
REQ-028 One sub-module, popcnt128, SHALL be used: combinational, DW-bit input to a $clog2(DW)+1-bit exact count, instantiated once and shared by muxing the granted requester's data into it.
REQ-029 All control and accumulator state SHALL be registered on Clk; the only combinational path is the data mux -> popcnt128 -> saturating adder.

Verification
REQ-030 Req0 only, 3-word frame, words all-ones, 0x0, 0xFF -> Res_Count=136, Res_Id=0, Res_Valid the cycle after the third accept.
REQ-031 Both valid at reset exit, 1-word frames 0xF and 0x3 held continuously -> results Id0 then Id1 then Id0 with counts 4, 2, 4.
REQ-032 ACCW=8, 3 all-ones 128-bit words -> Res_Count=255 (saturated), not 128.
REQ-033 Res_Ready low 5 cycles in DONE -> Res_Count and Res_Id stable, In*_Ready=0 throughout; accept -> IDLE the next cycle.
REQ-034 Rst pulsed after the 2nd word of a 4-word frame -> no result produced; the next frame reports only its own count.
REQ-035 Valid gaps mid-frame (2 idle cycles) -> Acc unchanged during the gap, and the final count is correct.
